// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration loader.
// Holds the FSM encoding and the width helpers used by the loader and its shift register.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } cfg_state_e;

    // The result is never below 1, so a single-entry range still gets a legal vector width.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int chunks_per_word(input int mem_size, input int chunk);
        return mem_size / chunk;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// CHUNK-in, MEM_SIZE-wide shift register that assembles one LUT truth table.
// The first chunk shifted in ends up in the MSBs.
module cfg_shift_reg #(
    parameter int MEM_SIZE = 16,
    parameter int CHUNK    = 1
) (
    input  logic                cclk,
    input  logic                crst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [CHUNK-1:0]    din,
    output logic [MEM_SIZE-1:0] shifted
);

    logic [MEM_SIZE-1:0] q;

    // shifted is the value q takes on a load; the top registers it on the final chunk.
    generate
        if (CHUNK == MEM_SIZE) begin : g_whole_word
            assign shifted = din;
        end else begin : g_shift
            assign shifted = {q[MEM_SIZE-CHUNK-1:0], din};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/lut_config_loader.sv
// Assembles a chunked configuration stream into MEM_SIZE-bit words and loads them
// into NUM_LUTS fractured LUTs, one registered one-hot cen pulse per word.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2 ** INPUTS,
    parameter int NUM_LUTS = 2,
    parameter int CHUNK    = 1,
    localparam int IDX_W   = clog2_min1(NUM_LUTS)
) (
    input  logic                cclk,
    input  logic                crst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CHUNK-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [MEM_SIZE-1:0] config_out,
    output logic [NUM_LUTS-1:0] cen_out,
    output logic [IDX_W-1:0]    lut_idx,
    output logic                busy,
    output logic                done
);

    localparam int CHUNKS = chunks_per_word(MEM_SIZE, CHUNK);
    localparam int CNT_W  = clog2_min1(CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
    localparam logic [IDX_W-1:0] LAST_LUT   = IDX_W'(NUM_LUTS - 1);

    cfg_state_e          state;
    logic [CNT_W-1:0]    chunk_cnt;
    logic                xfer;
    logic                sr_clr;
    logic [MEM_SIZE-1:0] word_next;

    // NOTE: in_ready decodes state alone; depending on in_valid here would create a valid->ready loop upstream.
    assign in_ready = (state == SHIFT);
    assign xfer     = in_ready && in_valid && !abort;
    assign sr_clr   = (abort && (state != IDLE))
                    || (start && !abort && ((state == IDLE) || (state == DONE)));

    cfg_shift_reg #(
        .MEM_SIZE (MEM_SIZE),
        .CHUNK    (CHUNK)
    ) u_shift_reg (
        .cclk    (cclk),
        .crst_n  (crst_n),
        .clr     (sr_clr),
        .load    (xfer),
        .din     (in_data),
        .shifted (word_next)
    );

    always_ff @(posedge cclk or negedge crst_n) begin
        if (!crst_n) begin
            state      <= IDLE;
            chunk_cnt  <= '0;
            lut_idx    <= '0;
            config_out <= '0;
            cen_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // cen_out is a single-cycle pulse; it is raised only on the edge that enters COMMIT.
            cen_out <= '0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                chunk_cnt <= '0;
                lut_idx   <= '0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start && !abort) begin
                            state     <= SHIFT;
                            chunk_cnt <= '0;
                            lut_idx   <= '0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (in_valid) begin
                            if (chunk_cnt == LAST_CHUNK) begin
                                chunk_cnt  <= '0;
                                state      <= COMMIT;
                                cen_out    <= NUM_LUTS'(1) << lut_idx;
                                config_out <= word_next;
                            end else begin
                                chunk_cnt <= chunk_cnt + 1'b1;
                            end
                        end
                    end
                    COMMIT: begin
                        if (lut_idx == LAST_LUT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            lut_idx <= lut_idx + 1'b1;
                            state   <= SHIFT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: a CHUNK=1/NUM_LUTS=2 instance and a
// CHUNK=4/NUM_LUTS=1 instance, checked against hand-computed words and pulse timing.
module tb_lut_config_loader;

    logic        cclk = 1'b0;
    logic        crst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [0:0]  in_data = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] config_out;
    logic [1:0]  cen_out;
    logic [0:0]  lut_idx;
    logic        busy;
    logic        done;

    logic        start4 = 1'b0;
    logic        abort4 = 1'b0;
    logic [3:0]  in_data4 = 4'h0;
    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [15:0] config4;
    logic [0:0]  cen4;
    logic [0:0]  idx4;
    logic        busy4;
    logic        done4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s;

    logic [15:0] cfg_q[$];
    logic [1:0]  cen_q[$];
    int          cyc_q[$];
    int          bad_inv = 0;
    int          ready_gap = 0;
    int          cen4_cnt = 0;
    logic [1:0]  prev_cen = 2'b00;

    lut_config_loader #(.INPUTS(4), .NUM_LUTS(2), .CHUNK(1)) dut (
        .cclk(cclk), .crst_n(crst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .config_out(config_out), .cen_out(cen_out), .lut_idx(lut_idx),
        .busy(busy), .done(done)
    );

    lut_config_loader #(.INPUTS(4), .NUM_LUTS(1), .CHUNK(4)) dut4 (
        .cclk(cclk), .crst_n(crst_n), .start(start4), .abort(abort4),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .config_out(config4), .cen_out(cen4), .lut_idx(idx4),
        .busy(busy4), .done(done4)
    );

    always #5 cclk = ~cclk;
    always @(posedge cclk) cyc <= cyc + 1;

    always @(negedge cclk) begin
        if (cen_out != 2'b00) begin
            cen_q.push_back(cen_out);
            cfg_q.push_back(config_out);
            cyc_q.push_back(cyc);
        end
        if ($countones(cen_out) > 1 || (cen_out != 2'b00 && prev_cen != 2'b00)) bad_inv++;
        if (busy && cen_out == 2'b00 && !in_ready) ready_gap++;
        prev_cen = cen_out;
        if (cen4 != 1'b0) cen4_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge cclk);
            #1;
        end
    endtask

    task automatic do_start(output int sc);
        start = 1'b1;
        @(posedge cclk);
        #1;
        sc = cyc;
        start = 1'b0;
    endtask

    task automatic push1(input logic b);
        logic rdy;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        do begin
            @(negedge cclk);
            rdy = in_ready;
            @(posedge cclk);
            #1;
            n++;
        end while (!rdy && n < 50);
        in_valid = 1'b0;
        if (!rdy) check("push_ready", {31'b0, rdy}, 32'd1);
    endtask

    task automatic send_bits(input logic [15:0] w, input int hi, input int lo, input bit toggle);
        for (int i = hi; i >= lo; i--) begin
            push1(w[i]);
            if (toggle) idle(1);
        end
    endtask

    task automatic clear_q();
        cen_q.delete();
        cfg_q.delete();
        cyc_q.delete();
    endtask

    task automatic check_loads(input string tag, input int n, input logic [15:0] w0, input logic [15:0] w1);
        check({tag, "_count"}, 32'(cen_q.size()), 32'(n));
        for (int i = 0; i < cen_q.size() && i < 2; i++) begin
            check({tag, "_cen"}, 32'(cen_q[i]), (i == 0) ? 32'd1 : 32'd2);
            check({tag, "_word"}, 32'(cfg_q[i]), (i == 0) ? 32'(w0) : 32'(w1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle(3);
        @(negedge cclk);
        check("rst_config_out", 32'(config_out), 32'h0);
        check("rst_cen_out", 32'(cen_out), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_lut_idx", 32'(lut_idx), 32'h0);
        crst_n = 1'b1;
        idle(2);

        // CHUNK=4 instance: D,E,A,D -> one cen pulse with 16'hDEAD
        start4 = 1'b1;
        idle(1);
        start4 = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            logic [15:0] dead;
            dead = 16'hDEAD;
            in_valid4 = 1'b1;
            in_data4 = dead[i*4 +: 4];
            idle(1);
        end
        in_valid4 = 1'b0;
        @(negedge cclk);
        check("c4_cen", 32'(cen4), 32'h1);
        check("c4_word", 32'(config4), 32'hDEAD);
        check("c4_busy", 32'(busy4), 32'h1);
        @(negedge cclk);
        check("c4_cen_after", 32'(cen4), 32'h0);
        check("c4_done", 32'(done4), 32'h1);
        check("c4_ready_done", 32'(in_ready4), 32'h0);
        check("c4_pulses", 32'(cen4_cnt), 32'd1);
        @(posedge cclk);
        #1;

        // Test 1: continuous stream, latency of both cen pulses
        clear_q();
        do_start(s);
        send_bits(16'hA5C3, 15, 0, 1'b0);
        send_bits(16'h0FF0, 15, 0, 1'b0);
        idle(2);
        @(negedge cclk);
        check_loads("t1", 2, 16'hA5C3, 16'h0FF0);
        if (cyc_q.size() == 2) begin
            check("t1_lat0", 32'(cyc_q[0] - s), 32'd16);
            check("t1_lat1", 32'(cyc_q[1] - s), 32'd33);
        end
        check("t1_done", 32'(done), 32'h1);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_ready", 32'(in_ready), 32'h0);
        check("t1_hold", 32'(config_out), 32'h0FF0);
        @(posedge cclk);
        #1;

        // Test 2: start from DONE restarts at lut_idx 0; valid toggles every cycle
        clear_q();
        ready_gap = 0;
        do_start(s);
        @(negedge cclk);
        check("t2_idx_restart", 32'(lut_idx), 32'h0);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_done_clr", 32'(done), 32'h0);
        @(posedge cclk);
        #1;
        send_bits(16'hA5C3, 15, 0, 1'b1);
        send_bits(16'h0FF0, 15, 0, 1'b1);
        idle(2);
        @(negedge cclk);
        check_loads("t2", 2, 16'hA5C3, 16'h0FF0);
        check("t2_ready_gaps", 32'(ready_gap), 32'd0);
        check("t2_done", 32'(done), 32'h1);
        @(posedge cclk);
        #1;

        // Test 6: start pulses in SHIFT and COMMIT are ignored
        clear_q();
        do_start(s);
        send_bits(16'h5A5A, 15, 11, 1'b0);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        @(negedge cclk);
        check("t6_idx_shift", 32'(lut_idx), 32'h0);
        @(posedge cclk);
        #1;
        send_bits(16'h5A5A, 10, 0, 1'b0);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        @(negedge cclk);
        check("t6_idx_commit", 32'(lut_idx), 32'h1);
        check("t6_busy", 32'(busy), 32'h1);
        @(posedge cclk);
        #1;
        send_bits(16'hC3C3, 15, 0, 1'b0);
        idle(2);
        @(negedge cclk);
        check_loads("t6", 2, 16'h5A5A, 16'hC3C3);
        @(posedge cclk);
        #1;

        // Test 4: abort after 9 chunks, chunk in abort cycle dropped, then clean reload
        clear_q();
        do_start(s);
        send_bits(16'hFFFF, 15, 7, 1'b0);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 1'b1;
        idle(1);
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge cclk);
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_ready", 32'(in_ready), 32'h0);
        check("t4_done", 32'(done), 32'h0);
        check("t4_idx", 32'(lut_idx), 32'h0);
        check("t4_no_cen", 32'(cen_q.size()), 32'd0);
        @(posedge cclk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        idle(1);
        start = 1'b0;
        abort = 1'b0;
        @(negedge cclk);
        check("t4_abort_wins", 32'(busy), 32'h0);
        @(posedge cclk);
        #1;
        do_start(s);
        send_bits(16'h1234, 15, 0, 1'b0);
        send_bits(16'h8001, 15, 0, 1'b0);
        idle(2);
        @(negedge cclk);
        check_loads("t4", 2, 16'h1234, 16'h8001);
        @(posedge cclk);
        #1;

        // Test 5: asynchronous reset in the middle of word 1
        clear_q();
        do_start(s);
        send_bits(16'hBEEF, 15, 0, 1'b0);
        send_bits(16'h0000, 15, 10, 1'b0);
        in_valid = 1'b1;
        in_data = 1'b1;
        #2;
        crst_n = 1'b0;
        #1;
        check("t5_config_out", 32'(config_out), 32'h0);
        check("t5_cen_out", 32'(cen_out), 32'h0);
        check("t5_ready", 32'(in_ready), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        check("t5_idx", 32'(lut_idx), 32'h0);
        idle(2);
        crst_n = 1'b1;
        idle(20);
        @(negedge cclk);
        check("t5_idle_busy", 32'(busy), 32'h0);
        check("t5_idle_ready", 32'(in_ready), 32'h0);
        check_loads("t5", 1, 16'hBEEF, 16'h0000);
        in_valid = 1'b0;

        check("invariants", 32'(bad_inv), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
Configuration-side stage directly upstream of the fractured LUT array. It accepts a serial/chunked configuration bitstream over a valid/ready handshake and assembles it into MEM_SIZE-bit words. It then drives the block-style config bus (config word plus a one-hot per-LUT cen) so each lut_fractured instance captures its full truth table on one cclk edge. It reports busy/done to the fabric configuration controller.

Parameters:
INPUTS, 4, LUT input count of each target lut_fractured instance.
MEM_SIZE, 2**INPUTS, config bits per LUT (width of the config_out bus).
NUM_LUTS, 2, number of LUT instances loaded in sequence; must be >= 1.
CHUNK, 1, bits accepted per handshake; must divide MEM_SIZE.

Ports:
cclk  input  1  configuration clock, shared with the LUTs' cclk.
crst_n  input  1  asynchronous active-low reset.
start  input  1  pulse that begins a full load of all NUM_LUTS words.
abort  input  1  synchronous cancel; returns the block to IDLE.
in_data  input  CHUNK  next configuration chunk.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader can accept a chunk this cycle.
config_out  output  MEM_SIZE  assembled word; connects to every LUT's config_in.
cen_out  output  NUM_LUTS  one-hot config enable, one bit per LUT.
lut_idx  output  clog2(NUM_LUTS) or 1  index of the LUT currently being filled.
busy  output  1  high in SHIFT or COMMIT.
done  output  1  high in DONE.

Behaviour:
- Clock and reset: one clock, cclk. Reset crst_n is asynchronous and active-low. All state is in cclk flops.
- Reset values: state=IDLE, shift register=0, chunk counter=0, lut_idx=0. Outputs: config_out=0, cen_out=0, in_ready=0, busy=0, done=0.
- Reset during a load: no cen pulse is emitted. A partially loaded LUT keeps its old contents.
- States: IDLE, SHIFT, COMMIT, DONE.
- IDLE:
  - in_ready=0.
  - start=1 clears the chunk counter and lut_idx, then moves to SHIFT.
- SHIFT:
  - in_ready=1.
  - A transfer occurs when in_valid&&in_ready.
  - On a transfer, shreg <= {shreg[MEM_SIZE-CHUNK-1:0], in_data} (first chunk ends up in the MSBs) and the chunk counter increments.
  - When the transfer carries chunk number MEM_SIZE/CHUNK-1, the counter wraps to 0 and the state moves to COMMIT.
  - in_valid=0 stalls SHIFT indefinitely with no state change.
- COMMIT (exactly one cycle):
  - in_ready=0.
  - cen_out = one-hot(lut_idx); config_out = the complete word, stable for the whole cycle.
  - The LUT captures the word on the cclk edge that ends COMMIT.
  - Next state: if lut_idx==NUM_LUTS-1, go to DONE; otherwise lut_idx++ and return to SHIFT.
- DONE:
  - done=1, in_ready=0.
  - Stays in DONE until start, which re-enters SHIFT with counters cleared.
- Outputs: config_out, cen_out, busy and done are registered (no combinational path from inputs). in_ready is a decode of state only, with no dependence on in_valid.
- Latency: the last chunk is accepted at edge k; cen_out is high from edge k to edge k+1; the LUT captures at edge k+1.
- Output invariants:
  - At most one cen_out bit is high in any cycle.
  - cen_out is 0 outside COMMIT.
  - config_out only changes after a COMMIT cycle completes, never while a cen bit is high.
- start while busy: ignored.
- abort (any state except IDLE):
  - Next state is IDLE and counters clear.
  - A chunk offered in the same cycle is dropped.
  - If abort lands in COMMIT, that cycle's cen pulse still completes, because cen_out is already registered.
- abort and start in the same cycle: abort wins.

Decomposition:
- Shared package/header lut_cfg_pkg holds:
  - state encoding localparams (IDLE/SHIFT/COMMIT/DONE);
  - CHUNKS_PER_WORD = MEM_SIZE/CHUNK;
  - a clog2 function for the counter widths.
- One natural sub-module, cfg_shift_reg: a parameterised CHUNK-in, MEM_SIZE-wide shift register with load-enable and clear. The FSM, counters and one-hot decode stay in the top level.

Test Plan:
1. INPUTS=4, CHUNK=1, NUM_LUTS=2; start, then stream 16'hA5C3 then 16'h0FF0 MSB-first with in_valid held high -> cen_out=2'b01 with config_out=16'hA5C3 on cycle 17, cen_out=2'b10 with config_out=16'h0FF0 on cycle 34, done=1 afterward, busy=0.
2. Same stream with in_valid toggling 1/0 every cycle -> identical config words and cen order, in_ready held high throughout SHIFT, no extra or missing chunks.
3. CHUNK=4: chunks 4'hD,4'hE,4'hA,4'hD -> one cen_out[0] pulse with config_out=16'hDEAD after the 4th accepted chunk.
4. abort after 9 chunks of word 0 -> state IDLE, cen_out never asserts, in_ready=0. A following start plus a full stream of 16'h1234 loads 16'h1234 correctly (no stale bits).
5. crst_n asserted asynchronously mid-SHIFT of word 1 -> all outputs 0 immediately, no cen pulse. After release, the block idles until start.
6. start pulses during SHIFT and COMMIT -> ignored (lut_idx and counters unchanged). start in DONE -> reload begins at lut_idx=0.
